uart_prog_loader: RTL and testbench

- On-chip end of the serial program-load link into the user project. The bench-side program transmitter drives the serial line, and this block receives it.
- Receives 8N1 UART bytes on a user IO pad and packs them little-endian into 32-bit words.
- Writes each word sequentially into instruction memory, then releases the core from reset when the end-of-program marker arrives.
- Sits between the mprj_io RX pad and the imem write port, alongside the core reset logic.

---
 rtl/uart_prog_loader_pkg.sv | 19 +
 rtl/uart_prog_loader_rx_core.sv | 135 +++++++++++++
 rtl/uart_prog_loader.sv | 103 ++++++++++
 tb/tb_uart_prog_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: RX FSM states and defaults.
package uart_prog_loader_pkg;

  // 40 MHz system clock divided down to 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEF = 347;

  // Word that terminates a program image; it is never stored.
  localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;

  // Receiver states; BREAK absorbs a low line after a bad stop bit.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-cycle byte strobe and a sticky framing-error flag.
module uart_rx_core
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_r, sync2_r;
  logic             rx_s;
  rx_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shreg_r, shreg_s;
  logic             byte_vld_r, byte_vld_s;
  logic             frame_err_r, frame_err_s;

  assign rx_s      = sync2_r;
  assign byte_vld  = byte_vld_r;
  assign rx_byte   = shreg_r;
  assign frame_err = frame_err_r;

  // Bring the asynchronous pad into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RX_IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shreg_r     <= 8'd0;
      byte_vld_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_idx_r   <= bit_idx_s;
      shreg_r     <= shreg_s;
      byte_vld_r  <= byte_vld_s;
      frame_err_r <= frame_err_s;
    end
  end

  // Next-state logic: centre on the start bit, then sample once per bit.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_idx_s   = bit_idx_r;
    shreg_s     = shreg_r;
    byte_vld_s  = 1'b0;
    frame_err_s = frame_err_r;
    case (state_r)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_s   = '0;
          state_s = RX_START;
        end else begin
          cnt_s = cnt_r;
        end
      end
      RX_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = '0;
          if (rx_s) begin
            state_s = RX_IDLE;
          end else begin
            bit_idx_s = 3'd0;
            state_s   = RX_DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_r == CNT_FULL) begin
          cnt_s              = '0;
          shreg_s[bit_idx_r] = rx_s;
          if (bit_idx_r == 3'd7) begin
            state_s = RX_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_r == CNT_FULL) begin
          cnt_s = '0;
          if (rx_s) begin
            byte_vld_s = 1'b1;
            state_s    = RX_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_s     = RX_BREAK;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RX_BREAK: begin
        if (rx_s) begin
          state_s = RX_IDLE;
        end else begin
          state_s = RX_BREAK;
        end
      end
      default: begin
        state_s = RX_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: packs received UART bytes little-endian into
// 32-bit words, writes them to imem and releases the core on END_WORD.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned ADDR_W       = 14,
  parameter logic [31:0] END_WORD     = END_WORD_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              prog_done_o,
  output logic              core_rst_o,
  output logic              frame_err_o
);

  logic              byte_vld_s;
  logic [7:0]        rx_byte_s;
  logic              frame_err_s;

  logic [1:0]        byte_idx_r;
  logic [23:0]       word_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              we_r;
  logic [31:0]       wdata_r;
  logic              done_r;
  logic              core_rst_r;

  logic [31:0]       word_full_s;
  logic              word_cplt_s;
  logic              is_end_s;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .rx_i     (rx_i),
    .byte_vld (byte_vld_s),
    .rx_byte  (rx_byte_s),
    .frame_err(frame_err_s)
  );

  assign imem_we_o    = we_r;
  assign imem_addr_o  = ptr_r;
  assign imem_wdata_o = wdata_r;
  assign prog_done_o  = done_r;
  assign core_rst_o   = core_rst_r;
  assign frame_err_o  = frame_err_s;

  // The incoming byte is the top byte of the word when three are held.
  always_comb begin
    word_full_s = {rx_byte_s, word_r};
    word_cplt_s = 1'b0;
    is_end_s    = 1'b0;
    if (byte_vld_s && !done_r && (byte_idx_r == 2'd3)) begin
      word_cplt_s = 1'b1;
      is_end_s    = (word_full_s == END_WORD);
    end else begin
      word_cplt_s = 1'b0;
      is_end_s    = 1'b0;
    end
  end

  // Word assembly, write strobe, address pointer and done/core-reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      byte_idx_r <= 2'd0;
      word_r     <= 24'd0;
      ptr_r      <= '0;
      we_r       <= 1'b0;
      wdata_r    <= 32'd0;
      done_r     <= 1'b0;
      core_rst_r <= 1'b1;
    end else begin
      we_r <= 1'b0;
      if (byte_vld_s && !done_r) begin
        byte_idx_r <= byte_idx_r + 2'd1;
        if (byte_idx_r != 2'd3) begin
          word_r[8*byte_idx_r +: 8] <= rx_byte_s;
        end
      end
      if (word_cplt_s) begin
        if (is_end_s) begin
          done_r     <= 1'b1;
          core_rst_r <= 1'b0;
        end else begin
          we_r    <= 1'b1;
          wdata_r <= word_full_s;
        end
      end
      // Advance only after the strobe so the write sees the old pointer.
      if (we_r) begin
        ptr_r <= ptr_r + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader using a byte-level reference model.
module tb_uart_prog_loader;

  localparam int          CPB  = 16;
  localparam int          AW   = 2;
  localparam logic [31:0] ENDW = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic          prog_done_o;
  logic          core_rst_o;
  logic          frame_err_o;

  int vectors     = 0;
  int miscompares = 0;

  // Observed writes (sampled on the falling edge) and expected writes.
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  time           obs_time[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  // Reference model state: byte list packed into words.
  logic [31:0] m_word;
  int          m_idx;
  int          m_ptr;
  bit          m_done;
  time         last_start;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .END_WORD    (ENDW)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_i        (rx),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .prog_done_o (prog_done_o),
    .core_rst_o  (core_rst_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we_o === 1'b1) begin
      obs_addr.push_back(imem_addr_o);
      obs_data.push_back(imem_wdata_o);
      obs_time.push_back($time);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_word = 32'd0;
    m_idx  = 0;
    m_ptr  = 0;
    m_done = 1'b0;
  endtask

  // A good byte lands at position m_idx; a full word is either the end
  // marker or the next write at the pointer, which wraps at 2^AW.
  task automatic model_byte(input logic [7:0] b);
    if (!m_done) begin
      m_word[8*m_idx +: 8] = b;
      if (m_idx == 3) begin
        m_idx = 0;
        if (m_word == ENDW) begin
          m_done = 1'b1;
        end else begin
          exp_addr.push_back(AW'(m_ptr));
          exp_data.push_back(m_word);
          m_ptr = (m_ptr + 1) % (1 << AW);
        end
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    last_start = $time;
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
    rx = 1'b1;
    wait_cyc(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"},    {63'd0, imem_we_o},   64'd0);
    chk({tag, "_addr"},  {62'd0, imem_addr_o}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, imem_wdata_o}, 64'd0);
    chk({tag, "_done"},  {63'd0, prog_done_o}, 64'd0);
    chk({tag, "_crst"},  {63'd0, core_rst_o},  64'd1);
    chk({tag, "_ferr"},  {63'd0, frame_err_o}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(3);
    check_reset_vals(tag);
    rst = 1'b0;
    model_reset();
    obs_addr.delete(); obs_data.delete(); obs_time.delete();
    exp_addr.delete(); exp_data.delete();
    wait_cyc(2);
  endtask

  task automatic check_writes(input string tag);
    int n;
    wait_cyc(4);
    chk({tag, "_nwr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
    end
    obs_addr.delete(); obs_data.delete(); obs_time.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  initial begin
    logic [31:0] w;
    int          lat;
    model_reset();

    // Power-on reset values.
    do_reset("por");

    // Single instruction then the end marker.
    send_word(32'h0010_0513);
    wait_cyc(2);
    chk("t1_wr_seen", 64'(obs_time.size()), 64'd1);
    if (obs_time.size() > 0) begin
      lat = int'((obs_time[0] - last_start) / 10);
      chk("t1_latency_win",
          {63'd0, (lat >= (CPB * 19) / 2) && (lat <= (CPB * 19) / 2 + 8)}, 64'd1);
    end
    check_writes("t1");
    send_word(ENDW);
    check_writes("t1_end");
    chk("t1_done", {63'd0, prog_done_o}, {63'd0, m_done});
    chk("t1_crst", {63'd0, core_rst_o}, {63'd0, !m_done});
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    check_writes("t1_post");
    chk("t1_ptr_frozen", 64'(imem_addr_o), 64'(m_ptr));

    // Three words then the end marker.
    do_reset("r2");
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(ENDW);
    check_writes("t2");
    chk("t2_done", {63'd0, prog_done_o}, 64'd1);

    // Short low glitch must not start a byte.
    do_reset("r3");
    @(posedge clk);
    #1;
    rx = 1'b0;
    wait_cyc(CPB / 4);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check_writes("t3");

    // Bad stop bit: flag sticks, byte is dropped, next byte accepted.
    do_reset("r4");
    send_frame(8'h55, 1'b0);
    wait_cyc(CPB);
    chk("t4_ferr", {63'd0, frame_err_o}, 64'd1);
    send_byte(8'h3C);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check_writes("t4");
    chk("t4_ferr_sticky", {63'd0, frame_err_o}, 64'd1);

    // Reset in the middle of a word.
    do_reset("r5");
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    do_reset("r5_mid");
    send_word(32'hDEAD_BEEF);
    check_writes("t5");

    // Pointer wrap with random words, then ignore traffic after done.
    do_reset("r6");
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      if (w == ENDW) w = ~w;
      send_word(w);
    end
    check_writes("t6");
    send_word(ENDW);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    check_writes("t6_post");
    chk("t6_done", {63'd0, prog_done_o}, 64'd1);
    chk("t6_ptr_frozen", 64'(imem_addr_o), 64'(m_ptr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
